debug_dump_sequencer: RTL and testbench

//  Debug-unit stage that consumes the pipeline snapshot store's output word. On a dump request it:
//  - drives the store's 4-bit control bus to capture a snapshot;
//  - walks snapshot words 2..11 and collects each 32-bit word;
//  - serializes each word MSB-first into bytes for the UART transmitter via a start/done handshake.

---
 rtl/debug_dump_sequencer_pkg.sv | 38 +++
 rtl/debug_dump_sequencer_serializer.sv | 76 +++++++
 rtl/debug_dump_sequencer.sv | 136 +++++++++++++
 tb/tb_debug_dump_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/debug_dump_sequencer_pkg.sv
// rtl/debug_dump_sequencer_pkg.sv - shared control codes, header default and FSM state encodings
package debug_dump_sequencer_pkg;

    localparam int WIDTH_WORD_DEFAULT        = 32;
    localparam int CANT_BITS_CONTROL_DEFAULT = 4;
    localparam int WIDTH_BYTE_DEFAULT        = 8;

    // Snapshot store control codes; any value >= 12 clears the store and must never be driven.
    localparam logic [3:0] CTRL_HOLD       = 4'd0;
    localparam logic [3:0] CTRL_CAPTURE    = 4'd1;
    localparam logic [3:0] CTRL_FIRST_WORD = 4'd2;
    localparam logic [3:0] CTRL_LAST_WORD  = 4'd11;

    localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

    // Top-level sequencing states; header states only exist when the header feature is built.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CAPTURE,
`ifdef DEBUG_DUMP_HEADER_EN
        ST_HDR,
        ST_HDR_WAIT,
`endif
        ST_SELECT,
        ST_WAIT,
        ST_LOAD,
        ST_XFER,
        ST_DONE
    } dump_state_e;

    // Byte serializer states: idle, present a byte, wait for the UART acknowledge.
    typedef enum logic [1:0] {
        SER_IDLE,
        SER_SEND,
        SER_WAIT_TX
    } ser_state_e;

endpackage

// File: rtl/debug_dump_sequencer_serializer.sv
// rtl/debug_dump_sequencer_serializer.sv - word-to-byte serializer with UART start/done handshake
module debug_dump_sequencer_serializer
    import debug_dump_sequencer_pkg::*;
#(
    parameter int WIDTH_WORD = WIDTH_WORD_DEFAULT,
    parameter int WIDTH_BYTE = WIDTH_BYTE_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  single_i,
    input  logic [WIDTH_WORD-1:0] word_i,
    input  logic                  tx_done_i,
    output logic [WIDTH_BYTE-1:0] tx_data_o,
    output logic                  tx_start_o,
    output logic                  last_byte_done_o
);

    localparam int BYTES_PER_WORD = WIDTH_WORD / WIDTH_BYTE;
    localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_WORD - 1);

    ser_state_e            state_q;
    logic [WIDTH_WORD-1:0] shift_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [WIDTH_BYTE-1:0] tx_data_q;
    logic                  tx_start_q;
    logic                  last_q;

    // Load a word (or a lone byte when single_i starts the count at the last slot), then emit MSByte-first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= SER_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            last_q     <= 1'b0;
            case (state_q)
                SER_IDLE: begin
                    if (load_i) begin
                        shift_q <= word_i;
                        cnt_q   <= single_i ? LAST_CNT : '0;
                        state_q <= SER_SEND;
                    end
                end
                SER_SEND: begin
                    tx_data_q  <= shift_q[WIDTH_WORD-1 -: WIDTH_BYTE];
                    tx_start_q <= 1'b1;
                    state_q    <= SER_WAIT_TX;
                end
                SER_WAIT_TX: begin
                    if (tx_done_i) begin
                        shift_q <= shift_q << WIDTH_BYTE;
                        if (cnt_q == LAST_CNT) begin
                            last_q  <= 1'b1;
                            state_q <= SER_IDLE;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            state_q <= SER_SEND;
                        end
                    end
                end
                default: state_q <= SER_IDLE;
            endcase
        end
    end

    assign tx_data_o        = tx_data_q;
    assign tx_start_o       = tx_start_q;
    assign last_byte_done_o = last_q;

endmodule

// File: rtl/debug_dump_sequencer.sv
// rtl/debug_dump_sequencer.sv - snapshot dump sequencer to UART; optional frame header via DEBUG_DUMP_HEADER_EN
module debug_dump_sequencer
    import debug_dump_sequencer_pkg::*;
#(
    parameter int WIDTH_WORD        = WIDTH_WORD_DEFAULT,
    parameter int CANT_BITS_CONTROL = CANT_BITS_CONTROL_DEFAULT,
    parameter int WIDTH_BYTE        = WIDTH_BYTE_DEFAULT,
    parameter int FIRST_INDEX       = 2,
`ifdef DEBUG_DUMP_HEADER_EN
    parameter logic [WIDTH_BYTE-1:0] HEADER_BYTE = HEADER_BYTE_DEFAULT,
`endif
    parameter int LAST_INDEX        = 11
) (
    input  logic                         i_clock,
    input  logic                         i_soft_reset,
    input  logic                         i_dump_request,
    input  logic [WIDTH_WORD-1:0]        i_dato,
    input  logic                         i_tx_done,
    output logic [CANT_BITS_CONTROL-1:0] o_control,
    output logic [WIDTH_BYTE-1:0]        o_tx_data,
    output logic                         o_tx_start,
    output logic                         o_busy,
    output logic                         o_dump_done
);

    localparam logic [CANT_BITS_CONTROL-1:0] IDX_FIRST = CANT_BITS_CONTROL'(FIRST_INDEX);
    localparam logic [CANT_BITS_CONTROL-1:0] IDX_LAST  = CANT_BITS_CONTROL'(LAST_INDEX);
    localparam logic [CANT_BITS_CONTROL-1:0] C_HOLD    = CANT_BITS_CONTROL'(CTRL_HOLD);
    localparam logic [CANT_BITS_CONTROL-1:0] C_CAPTURE = CANT_BITS_CONTROL'(CTRL_CAPTURE);

    dump_state_e                  state_q;
    logic [CANT_BITS_CONTROL-1:0] control_q;
    logic [CANT_BITS_CONTROL-1:0] index_q;
    logic                         busy_q;
    logic                         done_q;

    logic                  ser_load;
    logic                  ser_single;
    logic [WIDTH_WORD-1:0] ser_word;
    logic                  ser_last;

    // Serializer feed: snapshot word in LOAD, or the lone header byte in HDR.
    always_comb begin
        ser_load   = (state_q == ST_LOAD);
        ser_single = 1'b0;
        ser_word   = i_dato;
`ifdef DEBUG_DUMP_HEADER_EN
        if (state_q == ST_HDR) begin
            ser_load   = 1'b1;
            ser_single = 1'b1;
            ser_word   = {HEADER_BYTE, {(WIDTH_WORD-WIDTH_BYTE){1'b0}}};
        end
`endif
    end

    debug_dump_sequencer_serializer #(
        .WIDTH_WORD (WIDTH_WORD),
        .WIDTH_BYTE (WIDTH_BYTE)
    ) u_serializer (
        .clk_i            (i_clock),
        .rst_ni           (i_soft_reset),
        .load_i           (ser_load),
        .single_i         (ser_single),
        .word_i           (ser_word),
        .tx_done_i        (i_tx_done),
        .tx_data_o        (o_tx_data),
        .tx_start_o       (o_tx_start),
        .last_byte_done_o (ser_last)
    );

    // Dump sequencing; o_control is a non-hold code only on the single cycle a state owns it.
    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            state_q   <= ST_IDLE;
            control_q <= C_HOLD;
            index_q   <= IDX_FIRST;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            control_q <= C_HOLD;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_dump_request) begin
                        busy_q    <= 1'b1;
                        control_q <= C_CAPTURE;
                        state_q   <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
`ifdef DEBUG_DUMP_HEADER_EN
                    state_q   <= ST_HDR;
`else
                    control_q <= index_q;
                    state_q   <= ST_SELECT;
`endif
                end
`ifdef DEBUG_DUMP_HEADER_EN
                ST_HDR: state_q <= ST_HDR_WAIT;
                ST_HDR_WAIT: begin
                    if (ser_last) begin
                        control_q <= index_q;
                        state_q   <= ST_SELECT;
                    end
                end
`endif
                ST_SELECT: state_q <= ST_WAIT;
                ST_WAIT:   state_q <= ST_LOAD;
                ST_LOAD:   state_q <= ST_XFER;
                ST_XFER: begin
                    if (ser_last) begin
                        if (index_q < IDX_LAST) begin
                            index_q   <= index_q + 1'b1;
                            control_q <= index_q + 1'b1;
                            state_q   <= ST_SELECT;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    index_q <= IDX_FIRST;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_control   = control_q;
    assign o_busy      = busy_q;
    assign o_dump_done = done_q;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// tb/tb_debug_dump_sequencer.sv - randomized self-checking bench for debug_dump_sequencer
module tb_debug_dump_sequencer;

    logic        i_clock = 1'b0;
    logic        i_soft_reset = 1'b0;
    logic        i_dump_request = 1'b0;
    logic [31:0] i_dato = 32'h0;
    logic        i_tx_done = 1'b0;
    logic [3:0]  o_control;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_busy;
    logic        o_dump_done;

    int tests_run = 0;
    int tests_failed = 0;
    int range_err = 0;
    logic [3:0] ctl_q[$];
    logic [31:0] stage_q = 32'h0;

    debug_dump_sequencer dut (
        .i_clock        (i_clock),
        .i_soft_reset   (i_soft_reset),
        .i_dump_request (i_dump_request),
        .i_dato         (i_dato),
        .i_tx_done      (i_tx_done),
        .o_control      (o_control),
        .o_tx_data      (o_tx_data),
        .o_tx_start     (o_tx_start),
        .o_busy         (o_busy),
        .o_dump_done    (o_dump_done)
    );

    always #5 i_clock = ~i_clock;

    // Snapshot store model: word k appears on i_dato two cycles after selector k.
    always @(posedge i_clock) begin
        if (o_control >= 4'd2 && o_control <= 4'd11) stage_q <= 32'hC0DE_0000 + 32'(o_control);
        i_dato <= stage_q;
    end

    // Record every non-hold control code and police the legal range.
    always @(negedge i_clock) begin
        if (o_control != 4'd0) ctl_q.push_back(o_control);
        if (o_control > 4'd11) range_err++;
        assert (o_control <= 4'd11) else $error("o_control out of range: %0d", o_control);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete dump with random acknowledge delays; optional stall on byte stall_at and noise.
    task automatic run_dump(input string name, input int stall_at, input bit noise);
        logic [7:0]  exp_q[$];
        logic [7:0]  got_q[$];
        logic [3:0]  exp_ctl[$];
        logic [31:0] word;
        logic [7:0]  held = 8'h0;
        bit          outstanding = 0;
        int          wait_cnt = 0;
        int          cycles = 0;
        int          post = -1;
        int          done_cnt = 0;
        int          start_err = 0;
        int          stable_err = 0;
        int          ctl_err = 0;
        int          busy_err = 0;
`ifdef DEBUG_DUMP_HEADER_EN
        exp_q.push_back(8'hA5);
`endif
        exp_ctl.push_back(4'd1);
        for (int k = 2; k <= 11; k++) begin
            word = 32'hC0DE_0000 + 32'(k);
            exp_ctl.push_back(4'(k));
            for (int b = 3; b >= 0; b--) exp_q.push_back(word[b*8 +: 8]);
        end
        ctl_q.delete();
        i_dump_request = 1'b1;
        while (cycles < 6000 && post != 0) begin
            @(negedge i_clock);
            cycles++;
            i_dump_request = 1'b0;
            i_tx_done = 1'b0;
            if (post > 0) post--;
            if (o_dump_done) begin
                done_cnt++;
                if (post < 0) post = 6;
            end
            if (o_tx_start) begin
                if (outstanding) start_err++;
                if (!o_busy) busy_err++;
                got_q.push_back(o_tx_data);
                held = o_tx_data;
                outstanding = 1;
                wait_cnt = (got_q.size() - 1 == stall_at) ? 50 : int'($urandom_range(1, 5));
            end else if (outstanding && o_tx_data != held) begin
                stable_err++;
            end
            if (outstanding && o_control != 4'd0) ctl_err++;
            if (outstanding) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    i_tx_done = 1'b1;
                    outstanding = 0;
                end
            end else if (noise && $urandom_range(0, 3) == 0) begin
                i_tx_done = 1'b1;
            end
            if (noise && o_busy && !o_dump_done && $urandom_range(0, 7) == 0) i_dump_request = 1'b1;
        end
        i_dump_request = 1'b0;
        i_tx_done = 1'b0;
        chk_eq({name, " finished_in_budget"}, 32'(post == 0), 32'd1);
        chk_eq({name, " byte_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk_eq($sformatf("%s byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        chk_eq({name, " dump_done_pulses"}, done_cnt, 1);
        chk_eq({name, " extra_tx_start"}, start_err, 0);
        chk_eq({name, " tx_data_stable"}, stable_err, 0);
        chk_eq({name, " control_hold_during_tx"}, ctl_err, 0);
        chk_eq({name, " busy_during_tx"}, busy_err, 0);
        chk_eq({name, " busy_after"}, 32'(o_busy), 32'd0);
        chk_eq({name, " control_count"}, ctl_q.size(), exp_ctl.size());
        for (int i = 0; i < exp_ctl.size() && i < ctl_q.size(); i++)
            chk_eq($sformatf("%s control%0d", name, i), 32'(ctl_q[i]), 32'(exp_ctl[i]));
    endtask

    task automatic check_outputs_zero(input string name);
        chk_eq({name, " o_control"}, 32'(o_control), 32'd0);
        chk_eq({name, " o_tx_data"}, 32'(o_tx_data), 32'd0);
        chk_eq({name, " o_tx_start"}, 32'(o_tx_start), 32'd0);
        chk_eq({name, " o_busy"}, 32'(o_busy), 32'd0);
        chk_eq({name, " o_dump_done"}, 32'(o_dump_done), 32'd0);
    endtask

    initial begin
        bit seen = 0;
        repeat (3) @(negedge i_clock);
        check_outputs_zero("reset");
        i_soft_reset = 1'b1;
        @(negedge i_clock);
        chk_eq("idle_busy", 32'(o_busy), 32'd0);

        run_dump("plain", -1, 1'b0);
        run_dump("noisy_a", -1, 1'b1);
        run_dump("noisy_b", -1, 1'b1);
        run_dump("stall", 5, 1'b1);

        // Abort a dump while a byte is awaiting acknowledge.
        i_dump_request = 1'b1;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge i_clock);
            i_dump_request = 1'b0;
            if (o_tx_start) seen = 1;
        end
        chk_eq("abort reached_wait_tx", 32'(seen), 32'd1);
        repeat (2) @(negedge i_clock);
        #2 i_soft_reset = 1'b0;
        #1 check_outputs_zero("abort async");
        repeat (3) @(negedge i_clock);
        i_soft_reset = 1'b1;
        repeat (2) @(negedge i_clock);
        check_outputs_zero("abort released");

        run_dump("after_abort", -1, 1'b1);

        chk_eq("control_range", range_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
